// File: rtl/rtc_time_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared types and constants for the RTC timekeeping controller:
//               FSM state encoding, field widths, wrap limits and a helper
//               that range-checks a requested set time.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam int HOUR_W   = 5;
    localparam int MS_W     = 6;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        CHECK    = 2'd1,
        ACK      = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // True when every field of a requested time lies in its legal range.
    function automatic logic time_in_range(
        input logic [HOUR_W-1:0] h,
        input logic [MS_W-1:0]   m,
        input logic [MS_W-1:0]   s
    );
        return (h <= HOUR_W'(HOUR_MAX)) &&
               (m <= MS_W'(MIN_MAX))    &&
               (s <= MS_W'(SEC_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : rtc_mod_counter
// Description : Loadable modulo (MAX+1) wrap counter used for the seconds,
//               minutes and hours fields. carry is combinational so a whole
//               cascade resolves within one clock.
// Ports       : clk, rst (sync, active-high)
//               en       - advance by one this cycle
//               load     - load load_val (takes priority over en)
//               load_val - value to load
//               value    - registered count
//               carry    - en & (value == MAX): the next stage advances
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] r_value;
    logic         w_at_max;

    assign w_at_max = (r_value == W'(MAX));
    assign carry    = en & w_at_max;
    assign value    = r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (en) begin
            r_value <= w_at_max ? '0 : r_value + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_time_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rtc_time_ctrl
// Description : RTC timekeeping controller. Divides clk into a 1 s tick,
//               drives cascaded sec/min/hour counters (23:59:59 -> 00:00:00)
//               and arbitrates a set-time load through a req/ack handshake.
// Ports       : clk, rst (sync, active-high), run_en (advance/freeze)
//               set_req, set_hour, set_min, set_sec - set-time request
//               set_ack / set_err - one-cycle accept / reject pulses
//               hour, min, sec    - current time
//               sec_tick, day_wrap - one-cycle event pulses
// Options     : RTC_ALARM_EN adds alarm_hour, alarm_min, alarm_arm,
//               alarm_clr inputs and the sticky alarm output.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_time_ctrl
    import rtc_pkg::*;
#(
    parameter  int DIV   = 10,
    localparam int DIV_W = $clog2(DIV)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              set_req,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MS_W-1:0]   set_min,
    input  logic [MS_W-1:0]   set_sec,
`ifdef RTC_ALARM_EN
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MS_W-1:0]   alarm_min,
    input  logic              alarm_arm,
    input  logic              alarm_clr,
    output logic              alarm,
`endif
    output logic              set_ack,
    output logic              set_err,
    output logic [HOUR_W-1:0] hour,
    output logic [MS_W-1:0]   min,
    output logic [MS_W-1:0]   sec,
    output logic              sec_tick,
    output logic              day_wrap
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_presc;
    logic             w_presc_last;
    logic             w_set_valid;
    logic             w_count;
    logic             w_tick;
    logic             w_load;
    logic             w_ack;
    logic             w_err;
    logic             w_sec_carry;
    logic             w_min_carry;
    logic             w_hour_carry;
    logic             r_sec_tick;
    logic             r_day_wrap;

    assign w_presc_last = (r_presc == DIV_W'(DIV - 1));
    assign w_set_valid  = time_in_range(set_hour, set_min, set_sec);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending set request pre-empts counting in RUN, so a prescaler wrap
    // coinciding with the request is dropped rather than deferred.
    always_comb begin
        w_state_nxt = r_state;
        w_count     = 1'b0;
        w_tick      = 1'b0;
        w_load      = 1'b0;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            RUN: begin
                if (set_req) begin
                    w_state_nxt = CHECK;
                end else if (run_en) begin
                    w_count = 1'b1;
                    w_tick  = w_presc_last;
                end
            end
            CHECK: begin
                if (w_set_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ACK;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = WAIT_REL;
                end
            end
            ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (!set_req) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // set_ack is a decode of the ACK state register. set_err is decoded in
    // CHECK itself so the reject is visible one cycle after the request.
    assign set_ack = w_ack;
    assign set_err = w_err;

    // Prescaler restarts on a load so the first second after a set is full.
    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_presc <= '0;
        end else if (w_count) begin
            r_presc <= w_presc_last ? '0 : r_presc + DIV_W'(1);
        end
    end

    rtc_mod_counter #(.W(MS_W), .MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .en       (w_tick),
        .load     (w_load),
        .load_val (set_sec),
        .value    (sec),
        .carry    (w_sec_carry)
    );

    rtc_mod_counter #(.W(MS_W), .MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .en       (w_sec_carry),
        .load     (w_load),
        .load_val (set_min),
        .value    (min),
        .carry    (w_min_carry)
    );

    rtc_mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .en       (w_min_carry),
        .load     (w_load),
        .load_val (set_hour),
        .value    (hour),
        .carry    (w_hour_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
        end else begin
            r_sec_tick <= w_tick;
            r_day_wrap <= w_hour_carry;
        end
    end

    assign sec_tick = r_sec_tick;
    assign day_wrap = r_day_wrap;

`ifdef RTC_ALARM_EN
    // The match is evaluated against the time the current tick is about to
    // produce; only a tick that rolls seconds to 00 can hit. Loads never
    // assert w_sec_carry, so a set-time load cannot raise the alarm.
    logic [MS_W-1:0]   w_next_min;
    logic [HOUR_W-1:0] w_next_hour;
    logic              w_alarm_hit;
    logic              r_alarm;

    assign w_next_min  = w_min_carry ? '0 : min + MS_W'(1);
    assign w_next_hour = w_hour_carry ? '0 :
                         (w_min_carry ? hour + HOUR_W'(1) : hour);
    assign w_alarm_hit = w_sec_carry & alarm_arm &
                         (w_next_min == alarm_min) &
                         (w_next_hour == alarm_hour);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_hit) begin
            r_alarm <= 1'b1;
        end else if (alarm_clr) begin
            r_alarm <= 1'b0;
        end
    end

    assign alarm = r_alarm;
`endif

endmodule
`default_nettype wire

// File: doc/rtc_time_ctrl.md
Name: rtc_time_ctrl

Overview:
- Timekeeping controller for the real-time clock module.
- Divides the system clock into a 1-second tick.
- Sequences cascaded seconds/minutes/hours counters with carry and wrap-around (23:59:59 -> 00:00:00).
- Arbitrates between normal counting and a set-time load request via a req/ack handshake; feeds the display/alarm logic.

Parameters:
- DIV, 10, clk cycles per second tick; must be >= 2. Small default for simulation; silicon build overrides it.
- DIV_W, $clog2(DIV), prescaler width (derived; not user-set).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- run_en  in  1  1 = timekeeping advances; 0 = freeze (prescaler and time hold).
- set_req  in  1  level request to load a new time; held until set_ack or set_err seen.
- set_hour  in  5  requested hour, binary 0-23.
- set_min  in  6  requested minute, binary 0-59.
- set_sec  in  6  requested second, binary 0-59.
- set_ack  out  1  one-cycle pulse: load accepted.
- set_err  out  1  one-cycle pulse: load rejected (out-of-range field).
- hour  out  5  current hour, 0-23.
- min  out  6  current minute, 0-59.
- sec  out  6  current second, 0-59.
- sec_tick  out  1  one-cycle pulse on each seconds increment.
- day_wrap  out  1  one-cycle pulse coincident with the 23:59:59 -> 00:00:00 transition.

Behaviour:
- Reset (rst=1 at posedge): hour=min=sec=0, prescaler=0, state=RUN, all pulse outputs 0. Reset overrides everything, including a mid-handshake LOAD/ACK.
- FSM states: RUN, CHECK, ACK, WAIT_REL.
- RUN:
  - If set_req=1, go to CHECK; no tick this cycle, prescaler holds.
  - Otherwise, if run_en=1, prescaler increments; at DIV-1 it wraps to 0 and the tick fires in that same cycle.
  - If run_en=0, prescaler and time hold.
- Tick effect, registered at the same edge as the prescaler wrap:
  - sec+1; at 59, sec wraps to 0 and min+1.
  - min at 59 with carry wraps to 0 and hour+1.
  - hour at 23 with carry wraps to 0 and day_wrap=1.
  - sec_tick=1 for that one cycle.
- Carry is combinational within one cycle; no multi-cycle ripple.
- CHECK: set fields are sampled in this cycle.
  - All fields in range: load hour/min/sec, clear prescaler, go to ACK.
  - Otherwise: time unchanged, set_err=1 for one cycle, go to WAIT_REL.
- ACK: set_ack=1 for one cycle, then go to WAIT_REL.
- WAIT_REL: stay until set_req=0, then go to RUN. Time is frozen throughout CHECK/ACK/WAIT_REL.
- Latency:
  - set_req rise -> set_ack/set_err: set_ack at cycle +2, set_err at cycle +1.
  - New time visible on outputs the cycle after CHECK.
  - After returning to RUN, the first tick comes DIV cycles later.
- Simultaneous set_req and prescaler wrap in RUN: set wins; that tick is dropped (no sec_tick).
- run_en deassert mid-count: prescaler value is retained and resumes on reassert, so no partial-second loss.
- Outputs are registered.

Optional Feature:
- Macro: RTC_ALARM_EN.
- Defined:
  - Adds inputs alarm_hour[4:0], alarm_min[5:0], alarm_arm (1 bit), alarm_clr (1 bit), and output alarm (1 bit).
  - alarm is set at the tick that makes hour:min:sec equal alarm_hour:alarm_min:00 while alarm_arm=1.
  - alarm stays high until alarm_clr=1 (cleared next cycle) or rst.
  - alarm_clr and a new match in the same cycle: set wins.
  - A set-time load never triggers alarm.
- Undefined: none of these ports exist; no alarm logic is present.

Decomposition:
- Package rtc_pkg:
  - FSM state enum (RUN, CHECK, ACK, WAIT_REL).
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths HOUR_W=5, MS_W=6.
- Sub-module rtc_mod_counter, instantiated three times:
  - Parameterised wrap counter: inputs en, load, load_val; outputs value, carry.
  - carry = en & (value==MAX).

Test Plan:
- Reset then DIV=10, run_en=1 for 600 cycles -> sec_tick every 10 cycles, sec=0 and min=1 at cycle 600, exactly 60 sec_tick pulses.
- Load 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00; day_wrap high only on the second tick.
- set_req with 12:34:56 -> set_ack at +2 cycles; outputs 12:34:56; no tick until 10 cycles after set_req drops.
- set_req with set_min=60 -> set_err at +1 cycle, no set_ack, time unchanged; set_req raised exactly on the prescaler wrap cycle -> no sec_tick.
- run_en low for 7 cycles after 4 counted cycles -> next sec_tick occurs 6 cycles after reassert; rst asserted during ACK -> all outputs 0 next cycle, state RUN.
- RTC_ALARM_EN: arm 00:01, start from 00:00:58 -> alarm rises on the 2nd tick and stays high; alarm_clr drops it the next cycle.
